mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// Stalling load/store controller between the pipeline MEM stage and a request/ack memory.
// Optional watchdog on stuck accesses: define MEM_TIMEOUT_EN to add the counter and timeout_o.
module mem_access_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ReadData_o,
    output logic        pcEnable_o,
    output logic        misalign_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
`ifdef MEM_TIMEOUT_EN
    ,
    output logic        timeout_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic        any_req;
    logic        aligned;
    logic        access;
    logic        timeout_expire;

    assign any_req = MemRead_i | MemWrite_i;
    assign aligned = (addr_i[1:0] == 2'b00);
    assign access  = (state_q == S_IDLE) && any_req && aligned;

    // Bus outputs are decoded from the async-reset state so reset drops the request at once
    assign mem_req_o   = (state_q == S_WAIT);
    assign mem_we_o    = (state_q == S_WAIT) && we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign misalign_o  = !rst_i && (state_q == S_IDLE) && any_req && !aligned;

`ifdef MEM_TIMEOUT_EN
    logic [7:0] wait_cnt_q;
    logic       timeout_q;

    // The 255th consecutive WAIT cycle without ack is the one seen with a count of 254
    assign timeout_expire = (state_q == S_WAIT) && !mem_ack_i && (wait_cnt_q == 8'd254);
    assign timeout_o      = timeout_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            if (access) begin
                wait_cnt_q <= 8'd0;
            end else if ((state_q == S_WAIT) && !mem_ack_i) begin
                wait_cnt_q <= wait_cnt_q + 8'd1;
            end
            if (timeout_expire) begin
                timeout_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_expire = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            we_q       <= 1'b0;
            ReadData_o <= 32'd0;
        end else begin
            state_q <= state_d;
            // A simultaneous read+write request is handled as a write
            if (access) begin
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                we_q    <= MemWrite_i;
            end
            if ((state_q == S_WAIT) && mem_ack_i && !we_q) begin
                ReadData_o <= mem_rdata_i;
            end else if (timeout_expire && !we_q) begin
                ReadData_o <= 32'hDEADBEEF;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        pcEnable_o = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (access) begin
                    state_d    = S_WAIT;
                    pcEnable_o = 1'b0;
                end
            end
            S_WAIT: begin
                pcEnable_o = 1'b0;
                if (mem_ack_i || timeout_expire) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
